uart_rx_core: RTL and testbench

Receive-side companion to the UART transmitter core: deserialises 8N1 RS232 frames from the `uart_rx` pin into bytes for the host-side logic. Input is synchronised, 16x oversampled and majority-voted. Each received byte is presented with a one-cycle valid strobe. Stop-bit violations are flagged as framing errors. Sits between the board RX pin and the byte consumer (command parser/FIFO), on the same 50 MHz clock as the transmitter.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_core.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive/transmit types and helpers.
// Holds the oversampling constant and baud divisor math.
package uart_pkg;

  localparam int UART_OVS = 16;

  localparam int PH_SMP0 = 7;
  localparam int PH_SMP1 = 8;
  localparam int PH_SMP2 = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } TRxState;

  function automatic int uart_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / (baud * UART_OVS);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick divider with synchronous restart.
// Emits a one-clock tick every DIV clocks; restart realigns the phase.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0) && !i_restart;

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver, 16x oversampled with 2-of-3 voting.
// Delivers each byte with a one-cycle strobe; flags bad stop bits.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy_rx
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam int PHW = $clog2(OVS);

  logic [1:0]     r_sync;
  TRxState        r_state;
  logic [PHW-1:0] r_ph;
  logic [2:0]     r_bit;
  logic           r_s0;
  logic           r_s1;
  logic [7:0]     r_shreg;
  logic [7:0]     r_data;
  logic           r_valid;
  logic           r_ferr;
  logic           r_busy;

  TRxState        w_state_nxt;
  logic [PHW-1:0] w_ph_nxt;
  logic [PHW-1:0] w_ph_inc;
  logic [2:0]     w_bit_nxt;
  logic           w_s0_nxt;
  logic           w_s1_nxt;
  logic [7:0]     w_shreg_nxt;
  logic [7:0]     w_data_nxt;
  logic           w_valid_nxt;
  logic           w_ferr_nxt;
  logic           w_busy_nxt;
  logic           w_restart;
  logic           w_tick;
  logic           w_rxs;
  logic           w_maj;
  logic           w_at_mid;
  logic           w_at_end;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_restart(w_restart),
    .o_tick   (w_tick)
  );

  assign w_rxs    = r_sync[1];
  assign w_ph_inc = r_ph + 1'b1;
  assign w_maj    = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  assign w_at_mid = w_tick && (w_ph_inc == PHW'(PH_SMP2));
  assign w_at_end = w_tick && (w_ph_inc == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_ph    <= '0;
      r_bit   <= '0;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], uart_rx};
      r_state <= w_state_nxt;
      r_ph    <= w_ph_nxt;
      r_bit   <= w_bit_nxt;
      r_s0    <= w_s0_nxt;
      r_s1    <= w_s1_nxt;
      r_shreg <= w_shreg_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_bit_nxt   = r_bit;
    w_s0_nxt    = r_s0;
    w_s1_nxt    = r_s1;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    w_restart   = 1'b0;

    // ph counts ticks within the bit; samples land as it reaches 7, 8, 9
    if (w_tick) begin
      w_ph_nxt = w_ph_inc;
      if (w_ph_inc == PHW'(PH_SMP0)) w_s0_nxt = w_rxs;
      if (w_ph_inc == PHW'(PH_SMP1)) w_s1_nxt = w_rxs;
    end

    unique case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = S_START;
          w_ph_nxt    = '0;
          w_busy_nxt  = 1'b1;
          w_restart   = 1'b1;
        end
      end
      S_START: begin
        if (w_at_mid && w_maj) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (w_at_end) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_at_mid) begin
          w_shreg_nxt = {w_maj, r_shreg[7:1]};
        end
        if (w_at_end) begin
          w_bit_nxt = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // decide mid stop bit so the next start edge is caught early
        if (w_at_mid) begin
          if (w_maj) begin
            w_data_nxt  = r_shreg;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (w_rxs) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign busy_rx   = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized frame-level bench for the UART receiver.
// A byte/event reference model is compared against observed strobes.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int CLK_HZ = 50000000;
  localparam int BAUD   = 115200;
  localparam int TB_DIV = CLK_HZ / (BAUD * 16);
  localparam int PER    = CLK_HZ / BAUD;
  localparam int LAT    = 3 + (9 * 16 + 9) * TB_DIV + 1;
  localparam int PER_F  = PER * 100 / 103;
  localparam int PER_S  = PER * 100 / 97;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy_rx;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int viol = 0;
  int busy_rise_cyc = 0;
  int valid_cyc = 0;
  logic prev_v = 1'b0;
  logic prev_f = 1'b0;
  logic prev_b = 1'b0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  logic [7:0] m_last = 8'h00;

  uart_rx_core #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .OVS   (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy_rx  (busy_rx)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      obs_q.push_back({1'b0, rx_data});
      valid_cyc <= cyc;
    end
    if (frame_err) obs_q.push_back({1'b1, rx_data});
    if ((rx_valid && frame_err) ||
        (rx_valid && prev_v) ||
        (frame_err && prev_f)) viol <= viol + 1;
    if (busy_rx && !prev_b) busy_rise_cyc <= cyc;
    prev_v <= rx_valid;
    prev_f <= frame_err;
    prev_b <= busy_rx;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int per,
                      input bit stop_ok, input bit model);
    hold(1'b0, per);
    for (int i = 0; i < 8; i++) hold(b[i], per);
    hold(stop_ok, per);
    uart_rx = 1'b1;
    if (model) begin
      if (stop_ok) begin
        exp_q.push_back({1'b0, b});
        m_last = b;
      end else begin
        exp_q.push_back({1'b1, m_last});
      end
    end
  endtask

  task automatic flush(input string tag);
    hold(1'b1, 64);
    chk({tag, "/count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "/kind"}, 32'(obs_q[i].err), 32'(exp_q[i].err));
      chk({tag, "/data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int c0;
    int lat;
    int off;
    int per;
    int gap;
    bit ok;
    logic [7:0] b;

    repeat (5) @(posedge clk);
    #1;
    chk("rst/rx_data", 32'(rx_data), 32'h00);
    chk("rst/rx_valid", 32'(rx_valid), 32'h0);
    chk("rst/frame_err", 32'(frame_err), 32'h0);
    chk("rst/busy_rx", 32'(busy_rx), 32'h0);
    reset_n = 1'b1;
    hold(1'b1, 20);

    c0 = cyc;
    send(8'h55, PER, 1'b1, 1'b1);
    lat = valid_cyc - c0;
    chk("lat/busy", busy_rise_cyc - c0, 3);
    chk("lat/valid_window", 32'((lat >= LAT - 1) && (lat <= LAT + 1)), 1);
    send(8'hA3, PER, 1'b1, 1'b1);
    flush("single");

    send(8'h3C, PER, 1'b0, 1'b1);
    hold(1'b1, PER);
    send(8'h81, PER, 1'b1, 1'b1);
    flush("ferr");

    c0 = cyc;
    hold(1'b0, 100);
    hold(1'b1, 400);
    chk("glitch/busy_rise", busy_rise_cyc - c0, 3);
    chk("glitch/busy_low", 32'(busy_rx), 0);
    flush("glitch_none");
    send(8'hFF, PER, 1'b1, 1'b1);
    flush("glitch");

    c0 = cyc;
    hold(1'b0, $urandom_range(20, 150));
    hold(1'b1, 400);
    chk("rglitch/busy_rise", busy_rise_cyc - c0, 3);
    chk("rglitch/busy_low", 32'(busy_rx), 0);
    flush("rglitch");

    send(8'h00, PER_F, 1'b1, 1'b1);
    send(8'hFF, PER_F, 1'b1, 1'b1);
    send(8'h5A, PER_F, 1'b1, 1'b1);
    flush("b2b_fast");
    send(8'h00, PER_S, 1'b1, 1'b1);
    send(8'hFF, PER_S, 1'b1, 1'b1);
    send(8'h5A, PER_S, 1'b1, 1'b1);
    flush("b2b_slow");

    hold(1'b0, 20 * PER);
    exp_q.push_back({1'b1, m_last});
    chk("break/busy_hi", 32'(busy_rx), 1);
    hold(1'b1, 8);
    chk("break/busy_lo", 32'(busy_rx), 0);
    hold(1'b1, PER);
    send(8'h12, PER, 1'b1, 1'b1);
    flush("break");

    off = $urandom_range(5 * PER + 10, 6 * PER - 10);
    fork
      send(8'hC7, PER, 1'b1, 1'b0);
      begin
        repeat (off) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mrst/rx_data", 32'(rx_data), 32'h00);
        chk("mrst/rx_valid", 32'(rx_valid), 0);
        chk("mrst/frame_err", 32'(frame_err), 0);
        chk("mrst/busy_rx", 32'(busy_rx), 0);
      end
    join
    m_last = 8'h00;
    hold(1'b1, PER);
    reset_n = 1'b1;
    hold(1'b1, 20);
    send(8'hC7, PER, 1'b1, 1'b1);
    flush("mrst");

    for (int k = 0; k < 3; k++) begin
      b   = 8'($urandom);
      per = $urandom_range(PER_F, PER_S);
      ok  = ($urandom_range(0, 3) != 0);
      send(b, per, ok, 1'b1);
      gap = ok ? $urandom_range(0, 200) : per + $urandom_range(0, 200);
      hold(1'b1, gap);
    end
    flush("random");

    chk("pulse_rules", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
